bit_serial_subtractor: RTL and testbench

//  Computes A - B one bit per clock, LSB first, on a single full-adder cell.
//  The cell uses inverted B and carry-in = 1 (two's complement), so it is the inverse operation of the full-adder datapath.

---
 rtl/bit_serial_subtractor.sv | 107 ++++++++++
 tb/tb_bit_serial_subtractor.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_subtractor.sv
// Bit-serial A - B: one full-adder cell fed with ~B and carry-in 1, LSB first.
// Operands load in parallel on start; the result appears in parallel with a one-cycle done pulse.
module bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    count;
    logic             bit_sum;
    logic             carry_next;
    logic             last_bit;

    always_comb begin
        bit_sum    = a_sh[0] ^ b_sh[0] ^ carry;
        carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        last_bit   = (count == LAST);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy/done are flops loaded from the next state, so they line up with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            carry    <= 1'b0;
            count    <= '0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= ~b;
                        res_sh <= '0;
                        carry  <= 1'b1;
                        count  <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    res_sh <= {bit_sum, res_sh[WIDTH-1:1]};
                    carry  <= carry_next;
                    count  <= count + CW'(1);
                    // carry still holds the carry into the MSB on this edge
                    if (last_bit) begin
                        diff     <= {bit_sum, res_sh[WIDTH-1:1]};
                        borrow   <= ~carry_next;
                        overflow <= carry ^ carry_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor: directed cases, random WIDTH=8 operands,
// ignored start, mid-run abort, and an exhaustive back-to-back WIDTH=4 sweep.
module tb_bit_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8, done8, borrow8, overflow8;
    logic [7:0] diff8;
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4, done4, borrow4, overflow4;
    logic [3:0] diff4;

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    bit_serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .overflow(overflow8)
    );

    bit_serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .overflow(overflow4)
    );

    // Reference: plain integer subtraction and signed range test.
    function automatic void model(input int w, input int av, input int bv,
                                  output int d, output bit br, output bit ov);
        int m, sa, sb, r;
        m  = 1 << w;
        d  = (av - bv + m) % m;
        br = (av < bv);
        sa = (av >= m / 2) ? av - m : av;
        sb = (bv >= m / 2) ? bv - m : bv;
        r  = sa - sb;
        ov = (r < -(m / 2)) || (r > m / 2 - 1);
    endfunction

    // Issue one WIDTH=8 operation and wait (bounded) for done; returns what was observed.
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv,
                           output logic [7:0] d, output logic br, output logic ov,
                           output int lat, output int busy_cnt, output bit timed_out);
        @(negedge clk);
        a8 = av;
        b8 = bv;
        start8 = 1'b1;
        @(posedge clk);
        lat = 0;
        busy_cnt = 0;
        timed_out = 1'b1;
        d = '0;
        br = 1'b0;
        ov = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start8 = 1'b0;
                a8 = $urandom;
                b8 = $urandom;
            end
            if (busy8) busy_cnt++;
            if (done8) begin
                lat = n;
                d = diff8;
                br = borrow8;
                ov = overflow8;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({busy8, done8, diff8, borrow8, overflow8} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_w8 got busy=%b done=%b diff=%h borrow=%b ovf=%b exp all 0",
                     busy8, done8, diff8, borrow8, overflow8);
        end
        checks++;
        if ({busy4, done4, diff4, borrow4, overflow4} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_w4 got busy=%b done=%b diff=%h borrow=%b ovf=%b exp all 0",
                     busy4, done4, diff4, borrow4, overflow4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_directed;
        logic [7:0] av [5] = '{8'h05, 8'h03, 8'h80, 8'h00, 8'hFF};
        logic [7:0] bv [5] = '{8'h03, 8'h05, 8'h01, 8'h00, 8'hFF};
        logic [7:0] d;
        logic br, ov;
        int lat, bc, ed;
        bit to, ebr, eov;
        for (int i = 0; i < 5; i++) begin
            run_op8(av[i], bv[i], d, br, ov, lat, bc, to);
            model(8, int'(av[i]), int'(bv[i]), ed, ebr, eov);
            checks++;
            if (to) begin
                errors++;
                $display("[TB] FAIL directed_timeout %h-%h got no done exp done", av[i], bv[i]);
                continue;
            end
            checks++;
            if ({d, br, ov} !== {8'(ed), ebr, eov}) begin
                errors++;
                $display("[TB] FAIL directed_result %h-%h got diff=%h b=%b o=%b exp diff=%h b=%b o=%b",
                         av[i], bv[i], d, br, ov, 8'(ed), ebr, eov);
            end
            checks++;
            if (lat != 9 || bc != 8) begin
                errors++;
                $display("[TB] FAIL directed_timing got lat=%0d busy=%0d exp lat=9 busy=8", lat, bc);
            end
            @(negedge clk);
            checks++;
            if (done8 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL done_width got done=%b exp 0", done8);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] av, bv, d;
        logic br, ov;
        int lat, bc, ed;
        bit to, ebr, eov;
        for (int i = 0; i < 30; i++) begin
            av = $urandom;
            bv = $urandom;
            run_op8(av, bv, d, br, ov, lat, bc, to);
            model(8, int'(av), int'(bv), ed, ebr, eov);
            checks++;
            if (to || {d, br, ov} !== {8'(ed), ebr, eov} || lat != 9) begin
                errors++;
                $display("[TB] FAIL random %h-%h got diff=%h b=%b o=%b lat=%0d exp diff=%h b=%b o=%b lat=9",
                         av, bv, d, br, ov, lat, 8'(ed), ebr, eov);
            end
        end
    endtask

    task automatic test_ignore_start;
        int dones;
        logic [7:0] d;
        @(negedge clk);
        a8 = 8'h05;
        b8 = 8'h03;
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'h09;
        b8 = 8'h01;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dones = 0;
        d = '0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (done8) begin
                dones++;
                d = diff8;
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("[TB] FAIL ignore_start_dones got %0d exp 1", dones);
        end
        checks++;
        if (d !== 8'h02) begin
            errors++;
            $display("[TB] FAIL ignore_start_diff got %h exp 02", d);
        end
    endtask

    task automatic test_abort;
        int dones;
        logic [7:0] d;
        logic br, ov;
        int lat, bc;
        bit to;
        @(negedge clk);
        a8 = 8'h10;
        b8 = 8'h01;
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, diff8, borrow8, overflow8} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL abort_clear got busy=%b done=%b diff=%h borrow=%b ovf=%b exp all 0",
                     busy8, done8, diff8, borrow8, overflow8);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done8 || busy8) dones++;
        end
        checks++;
        if (dones != 0 || diff8 !== 8'h00) begin
            errors++;
            $display("[TB] FAIL abort_no_done got activity=%0d diff=%h exp 0 and 00", dones, diff8);
        end
        run_op8(8'h10, 8'h01, d, br, ov, lat, bc, to);
        checks++;
        if (to || {d, br, ov} !== {8'h0F, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL abort_restart got diff=%h b=%b o=%b to=%b exp diff=0f b=0 o=0",
                     d, br, ov, to);
        end
    endtask

    task automatic test_back_to_back4;
        int ed, last_cycle, bad, bad_gap;
        bit ebr, eov, seen;
        @(negedge clk);
        a4 = 4'd0;
        b4 = 4'd0;
        start4 = 1'b1;
        last_cycle = 0;
        bad = 0;
        bad_gap = 0;
        for (int i = 0; i < 256; i++) begin
            seen = 1'b0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (done4) begin
                    seen = 1'b1;
                    break;
                end
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("[TB] FAIL w4_timeout pair %0d got no done exp done", i);
                break;
            end
            model(4, i >> 4, i & 15, ed, ebr, eov);
            checks++;
            if ({diff4, borrow4, overflow4} !== {4'(ed), ebr, eov}) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("[TB] FAIL w4_result %0d-%0d got diff=%h b=%b o=%b exp diff=%h b=%b o=%b",
                             i >> 4, i & 15, diff4, borrow4, overflow4, 4'(ed), ebr, eov);
            end
            if (i > 0) begin
                checks++;
                if (cycle - last_cycle != 6) begin
                    errors++;
                    bad_gap++;
                    if (bad_gap <= 5)
                        $display("[TB] FAIL w4_spacing got %0d exp 6", cycle - last_cycle);
                end
            end
            last_cycle = cycle;
            if (i < 255) begin
                a4 = 4'((i + 1) >> 4);
                b4 = 4'((i + 1) & 15);
            end else begin
                start4 = 1'b0;
            end
        end
    endtask

    initial begin
        $display("[TB] starting bit_serial_subtractor bench");
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_abort();
        test_back_to_back4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
